// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared constants and types for the VGA scan path.
//   - Default 640x480@60 timing (25 MHz pixel rate from a 50 MHz clock) and
//     the totals / sync windows derived from it.
//   - rgb_t    : 24-bit {R,G,B} colour word.
//   - coord_t  : pixel / line coordinate (COORD_W bits).
//   - sync_t   : the {hs, vs, vis} bundle that rides the alignment pipeline.
package vga_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 24;

  // Horizontal timing, in pixels.
  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;

  // Vertical timing, in lines.
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOTAL = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
  localparam int V_TOTAL = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

  // Sync pulses are low on [START, END).
  localparam int H_SYNC_START = H_VIS_DEF + H_FP_DEF;       // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;  // 752
  localparam int V_SYNC_START = V_VIS_DEF + V_FP_DEF;       // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;  // 492

  typedef logic [RGB_W-1:0]   rgb_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hs;   // active-low horizontal sync
    logic vs;   // active-low vertical sync
    logic vis;  // inside the visible window
  } sync_t;

  // Value of a pipeline slot that holds no pixel: syncs idle high, blanked.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

  // True when lo <= pos < hi.
  function automatic logic in_window(coord_t pos, coord_t lo, coord_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay
//   DEPTH-stage shift register for the {hs, vs, vis} bundle. Advances only on
//   the pixel strobe so the raw timing lines up with colour that returns from
//   the renderer DEPTH pixel ticks after its request.
//
//   clk    in   system clock
//   reset  in   synchronous, active-high; every stage returns to SYNC_IDLE
//   pe     in   pixel-enable strobe, one clk wide
//   din    in   raw timing for the current pixel
//   dout   out  timing delayed by DEPTH pixel ticks
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  pe,
  input  sync_t din,
  output sync_t dout
);

  sync_t [DEPTH-1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sync_pipe[i] <= SYNC_IDLE;
    end else if (pe) begin
      sync_pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign dout = sync_pipe[DEPTH-1];

endmodule

// File: rtl/vga_scan_controller.sv
// vga_scan_controller
//   VGA raster generator. Divides clk down to the pixel rate, walks the
//   h/v raster, issues one (x,y) read request per visible pixel to the
//   renderer, and drives the DAC pins with colour that returns RD_LAT pixel
//   ticks later. Sync and blank are delayed by the same amount so they stay
//   aligned with the colour.
//
//   clk          in   system clock (50 MHz)
//   reset        in   synchronous, active-high
//   pix_rgb      in   {R,G,B} from the renderer, sampled on pixel ticks only
//   fb_x, fb_y   out  requested pixel column / row
//   fb_req       out  one-clk request strobe, visible pixels only
//   frame_start  out  one-clk pulse on the tick at h=0, v=0
//   VGA_CLK      out  pixel clock to the DAC, rises mid-pixel
//   VGA_HS/VS    out  active-low syncs
//   VGA_BLANK_N  out  low outside the visible window
//   VGA_SYNC_N   out  tied low
//   VGA_R/G/B    out  colour, zero while blanked
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF,
  parameter int RD_LAT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RGB_W-1:0]   pix_rgb,
  output logic [COORD_W-1:0] fb_x,
  output logic [COORD_W-1:0] fb_y,
  output logic               fb_req,
  output logic               frame_start,
  output logic               VGA_CLK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B
);

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  // ---------------------------------------------------------------------
  // Pixel-rate divider. pe and VGA_CLK are registered from the next count,
  // so pe is high exactly while cnt == CLK_DIV-1 and VGA_CLK is high while
  // cnt is in the upper half. Outputs move on the pe edge, which leaves
  // VGA_CLK rising half a pixel later on settled data.
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pe;

  assign cnt_nxt = (cnt == CNT_W'(CLK_DIV - 1)) ? '0 : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pe      <= 1'b0;
      VGA_CLK <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      pe      <= (cnt_nxt == CNT_W'(CLK_DIV - 1));
      VGA_CLK <= (cnt_nxt >= CNT_W'(CLK_DIV / 2));
    end
  end

  // ---------------------------------------------------------------------
  // Raster counters. h/v name the pixel being requested on the next pe.
  // ---------------------------------------------------------------------
  coord_t h;
  coord_t v;
  logic   h_last;
  logic   v_last;

  assign h_last = (h == coord_t'(H_TOT - 1));
  assign v_last = (v == coord_t'(V_TOT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (pe) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + coord_t'(1);
      end else begin
        h <= h + coord_t'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Raw timing for the pixel at (h, v).
  // ---------------------------------------------------------------------
  sync_t raw;
  sync_t dly;

  always_comb begin
    raw     = SYNC_IDLE;
    raw.hs  = ~in_window(h, coord_t'(HS_START), coord_t'(HS_END));
    raw.vs  = ~in_window(v, coord_t'(VS_START), coord_t'(VS_END));
    raw.vis = (h < coord_t'(H_VIS)) && (v < coord_t'(V_VIS));
  end

  // ---------------------------------------------------------------------
  // Request stage. Coordinates are loaded every tick (they simply track the
  // raster); the strobes are one clk wide and dropped on the following clk.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_x        <= '0;
      fb_y        <= '0;
      fb_req      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      fb_req      <= 1'b0;
      frame_start <= 1'b0;
      if (pe) begin
        fb_x        <= h;
        fb_y        <= v;
        fb_req      <= raw.vis;
        frame_start <= (h == '0) && (v == '0);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Alignment: timing travels RD_LAT ticks, the same time the renderer needs
  // to answer, so the last stage describes the pixel whose colour is on
  // pix_rgb at this pe.
  // ---------------------------------------------------------------------
  vga_sync_delay #(
    .DEPTH (RD_LAT)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .pe    (pe),
    .din   (raw),
    .dout  (dly)
  );

  // ---------------------------------------------------------------------
  // Pin registers. Colour is gated by the delayed visible flag so anything
  // the renderer drives during blanking never reaches the DAC.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pe) begin
      VGA_HS      <= dly.hs;
      VGA_VS      <= dly.vs;
      VGA_BLANK_N <= dly.vis;
      if (dly.vis) begin
        VGA_R <= pix_rgb[23:16];
        VGA_G <= pix_rgb[15:8];
        VGA_B <= pix_rgb[7:0];
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
    end
  end

  // Composite sync on the green channel is never used.
  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_scan_controller.sv
// tb_vga_scan_controller
//   Self-checking bench for vga_scan_controller. A shrunken raster keeps whole
//   frames short; all expectations are derived from the same parameters.
//   A renderer model answers each pixel tick with {x[7:0], y[7:0], A5} for
//   visible coordinates and FFFFFF otherwise; the expected colour of every
//   request is queued and popped when a visible pixel reaches the pins.
module tb_vga_scan_controller;

  localparam int CLK_DIV   = 2;
  localparam int H_VIS     = 16;
  localparam int H_FP      = 2;
  localparam int H_SYNC    = 4;
  localparam int H_BP      = 3;
  localparam int V_VIS     = 6;
  localparam int V_FP      = 2;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 3;
  localparam int RD_LAT    = 2;  // renderer model below is written for 2
  localparam int H_TOT     = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT     = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int LINE_CLK  = H_TOT * CLK_DIV;
  localparam int FRAME_CLK = LINE_CLK * V_TOT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] pix_rgb;
  logic [9:0]  fb_x, fb_y;
  logic        fb_req, frame_start, VGA_CLK, VGA_HS, VGA_VS;
  logic        VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  vga_scan_controller #(
    .CLK_DIV (CLK_DIV), .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC),
    .H_BP (H_BP), .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC),
    .V_BP (V_BP), .RD_LAT (RD_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_rgb     (pix_rgb),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .fb_req      (fb_req),
    .frame_start (frame_start),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] model_rgb(logic [9:0] x, logic [9:0] y);
    if (x < 10'(H_VIS) && y < 10'(V_VIS)) return {x[7:0], y[7:0], 8'hA5};
    return 24'hFFFFFF;
  endfunction

  // Renderer: on the clk before each pixel tick, present the colour of the
  // request made one tick earlier, so it is sampled RD_LAT ticks after it.
  initial begin
    logic [23:0] nxt;
    nxt     = 24'h0;
    pix_rgb = 24'h0;
    forever begin
      @(negedge clk);
      if (VGA_CLK) begin
        pix_rgb = nxt;
        nxt     = model_rgb(fb_x, fb_y);
      end
    end
  end

  // Scoreboard: requests push, visible pixels on the pins pop.
  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } exp_t;
  exp_t       sbq[$];
  exp_t       sb_e;
  logic [9:0] ex, ey;

  always @(negedge clk) begin
    if (mon_en && !reset && fb_req) begin
      chk("req_x", 32'(fb_x), 32'(ex));
      chk("req_y", 32'(fb_y), 32'(ey));
      sbq.push_back('{x: ex, y: ey, rgb: {ex[7:0], ey[7:0], 8'hA5}});
      if (ex == 10'(H_VIS - 1)) begin
        ex = '0;
        ey = (ey == 10'(V_VIS - 1)) ? 10'd0 : ey + 10'd1;
      end else begin
        ex = ex + 10'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && !reset && VGA_CLK) begin
      if (VGA_BLANK_N) begin
        chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          sb_e = sbq.pop_front();
          chk("pin_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(sb_e.rgb));
          if (sb_e.x == 10'(H_VIS - 1))
            chk("last_col_r", 32'(VGA_R), 32'((H_VIS - 1) % 256));
        end
      end else begin
        chk("blank_rgb_zero", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
      end
    end
  end

  // Pulse widths and periods measured in clk at the pins.
  int cyc = 0;
  logic p_hs, p_vs, p_bl, p_fs;
  int t_hs, t_vs, t_bl, t_fs;
  bit h_hs, h_vs, h_bl, h_fs;
  int n_hs_per, n_vs_per, n_fs_per;

  always @(negedge clk) begin
    cyc++;
    if (reset || !mon_en) begin
      p_hs = 1'b1; p_vs = 1'b1; p_bl = 1'b0; p_fs = 1'b0;
      h_hs = 1'b0; h_vs = 1'b0; h_bl = 1'b0; h_fs = 1'b0;
      n_hs_per = 0; n_vs_per = 0; n_fs_per = 0;
    end else begin
      if (p_hs && !VGA_HS) begin
        if (h_hs) begin
          chk("hs_period", 32'(cyc - t_hs), 32'(LINE_CLK));
          n_hs_per++;
        end
        t_hs = cyc; h_hs = 1'b1;
      end
      if (!p_hs && VGA_HS && h_hs) chk("hs_width", 32'(cyc - t_hs), 32'(H_SYNC * CLK_DIV));
      if (p_vs && !VGA_VS) begin
        if (h_vs) begin
          chk("vs_period", 32'(cyc - t_vs), 32'(FRAME_CLK));
          n_vs_per++;
        end
        t_vs = cyc; h_vs = 1'b1;
      end
      if (!p_vs && VGA_VS && h_vs) chk("vs_width", 32'(cyc - t_vs), 32'(V_SYNC * LINE_CLK));
      if (!p_bl && VGA_BLANK_N) begin t_bl = cyc; h_bl = 1'b1; end
      if (p_bl && !VGA_BLANK_N && h_bl) chk("blank_n_width", 32'(cyc - t_bl), 32'(H_VIS * CLK_DIV));
      if (p_fs) chk("frame_start_1clk", 32'(frame_start), 32'd0);
      if (frame_start && !p_fs) begin
        if (h_fs) begin
          chk("frame_start_period", 32'(cyc - t_fs), 32'(FRAME_CLK));
          n_fs_per++;
        end
        t_fs = cyc; h_fs = 1'b1;
      end
      p_hs = VGA_HS; p_vs = VGA_VS; p_bl = VGA_BLANK_N; p_fs = frame_start;
    end
  end

  task automatic check_reset_outputs();
    chk("rst_hs", 32'(VGA_HS), 32'd1);
    chk("rst_vs", 32'(VGA_VS), 32'd1);
    chk("rst_blank_n", 32'(VGA_BLANK_N), 32'd0);
    chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    chk("rst_sync_n", 32'(VGA_SYNC_N), 32'd0);
    chk("rst_vga_clk", 32'(VGA_CLK), 32'd0);
    chk("rst_fb_req", 32'(fb_req), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_fb_xy", 32'({fb_x, fb_y}), 32'd0);
  endtask

  // Release reset on a negedge; frame_start and the (0,0) request must show
  // two clk later.
  task automatic release_and_check();
    @(negedge clk);
    sbq.delete();
    ex     = '0;
    ey     = '0;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("fs_after_1clk", 32'(frame_start), 32'd0);
    chk("vga_clk_after_1clk", 32'(VGA_CLK), 32'd1);
    @(negedge clk);
    chk("fs_after_2clk", 32'(frame_start), 32'd1);
    chk("first_req", 32'(fb_req), 32'd1);
    chk("first_req_xy", 32'({fb_x, fb_y}), 32'd0);
  endtask

  initial begin
    bit found;

    // Power-on reset, 4 clk.
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();

    release_and_check();

    // First visible pixel at the pins is (0,0).
    found = 1'b0;
    for (int i = 0; i < 4 * LINE_CLK && !found; i++) begin
      @(negedge clk);
      if (VGA_BLANK_N) found = 1'b1;
    end
    chk("first_pixel_seen", 32'(found), 32'd1);
    chk("first_pixel_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0000A5);

    // Free-run three frames under the monitors.
    repeat (3 * FRAME_CLK) @(negedge clk);
    chk("hs_periods_seen", 32'(n_hs_per != 0), 32'd1);
    chk("vs_periods_seen", 32'(n_vs_per != 0), 32'd1);
    chk("fs_periods_seen", 32'(n_fs_per != 0), 32'd1);

    // Mid-frame reset at line 3, pixel 10 of the shrunken raster.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
      @(negedge clk);
      if (fb_req && fb_y == 10'd3 && fb_x == 10'd10) found = 1'b1;
    end
    chk("midframe_point_seen", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    repeat (3) @(negedge clk);
    check_reset_outputs();

    release_and_check();
    repeat (2 * FRAME_CLK + LINE_CLK) @(negedge clk);
    chk("vs_periods_after_rst", 32'(n_vs_per != 0), 32'd1);
    chk("fs_periods_after_rst", 32'(n_fs_per != 0), 32'd1);
    chk("sync_n_low", 32'(VGA_SYNC_N), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
